// File: rtl/seq_divider_if.sv
// seq_divider_if: start/operand request and result bundle for seq_divider.
// The requester drives through the master modport, the divider through slave.
interface seq_divider_if #(
  parameter int unsigned N = 4
) ();

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Results are registered on entry to DONE and held until the next DONE.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's complement operands via
// magnitude pre-step and sign fix-up on entry to DONE (truncation toward zero).
module seq_divider #(
  parameter int unsigned N = 4
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_rem;        // partial remainder
  logic [N-1:0]  r_quo;        // dividend bits shift out MSB, quotient bits shift in LSB
  logic [N-1:0]  r_dvs;
  logic [N-1:0]  r_quotient;
  logic [N-1:0]  r_remainder;
  logic          r_dbz;

  logic          w_accept;
  logic          w_dvs_zero;
  logic [N-1:0]  w_dvd_mag;
  logic [N-1:0]  w_dvs_mag;
  logic [N:0]    w_shift;
  logic [N+1:0]  w_diff;
  logic          w_ge;
  logic [N-1:0]  w_rem_nxt;
  logic [N-1:0]  w_quo_nxt;
  logic [N-1:0]  w_quo_fin;
  logic [N-1:0]  w_rem_fin;

  assign w_accept   = (r_state == StIdle) && bus.start;
  assign w_dvs_zero = (bus.divisor == '0);

  // One restoring step: shift in next dividend bit, trial-subtract, keep on no borrow.
  assign w_shift   = {r_rem, r_quo[N-1]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_ge      = ~w_diff[N+1];
  assign w_rem_nxt = N'(w_ge ? w_diff : {1'b0, w_shift});
  assign w_quo_nxt = {r_quo[N-2:0], w_ge};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_dvd_mag = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
  assign w_dvs_mag = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;
  assign w_quo_fin = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fin = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  // Record operand signs on the accepted start; held through RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= bus.dividend[N-1] ^ bus.divisor[N-1];
      r_neg_r <= bus.dividend[N-1];
    end
  end
`else
  assign w_dvd_mag = bus.dividend;
  assign w_dvs_mag = bus.divisor;
  assign w_quo_fin = w_quo_nxt;
  assign w_rem_fin = w_rem_nxt;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_nxt = w_dvs_zero ? StDone : StRun;
        end
      end
      StRun: begin
        bus.busy = 1'b1;
        if (r_count == '0) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        bus.done    = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Working registers and result registers; results change only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_count <= LastCnt;
            r_rem   <= '0;
            r_quo   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            if (w_dvs_zero) begin
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_dbz <= 1'b0;
            end
          end
        end
        StRun: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_count == '0) begin
            r_quotient  <= w_quo_fin;
            r_remainder <= w_rem_fin;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scenario-task bench for seq_divider (N=4) with a result
// scoreboard fed by a division model; honours SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2 * N + 1;  // {dbz, quotient, remainder}

  logic clk = 1'b0;
  logic rst;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] got_v;

  function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] q;
    logic [N-1:0] r;
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa, sb, iq, ir;
`endif
    if (b == '0) return {1'b1, {N{1'b1}}, a};
`ifdef SEQ_DIVIDER_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
    iq = sa / sb;
    ir = sa % sb;
    q  = iq[N-1:0];
    r  = ir[N-1:0];
`else
    q = a / b;
    r = a % b;
`endif
    return {1'b0, q, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start cycle and record the expected result.
  task automatic start_div(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    exp_q.push_back(model(a, b));
    tick();
    bus.start = 1'b0;
  endtask

  // Wait (bounded) until done is seen; reports cycles waited and busy cycles seen.
  task automatic wait_done(input int max, output int cycles, output int busy_n, output bit got);
    cycles = 0;
    busy_n = 0;
    got    = 1'b0;
    while (!got && cycles <= max) begin
      if (bus.done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (bus.busy === 1'b1) busy_n++;
        tick();
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    n_checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%b r=%b, want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    int  c, b;
    bit  g;
    start_div(4'd13, 4'd4);
    wait_done(20, c, b, g);
    n_checks++;
    if (!g || c != N || b != N) begin
      n_fail++;
      $display("FAIL basic_latency: got done=%b cycles=%0d busy=%0d, want 1 %0d %0d",
               g, c, b, N, N);
    end
    if (g) begin
      got_v = {bus.div_by_zero, bus.quotient, bus.remainder};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL basic_result: got dbz=%b q=%b r=%b, want dbz=%b q=%b r=%b",
                 got_v[2*N], got_v[2*N-1:N], got_v[N-1:0],
                 exp_v[2*N], exp_v[2*N-1:N], exp_v[N-1:0]);
      end
    end else begin
      exp_q.delete();
    end
    tick();
    n_checks++;
    if ({bus.done, bus.busy} !== 2'b00 ||
        {bus.div_by_zero, bus.quotient, bus.remainder} !== exp_v) begin
      n_fail++;
      $display("FAIL basic_pulse_hold: got done=%b busy=%b q=%b r=%b, want 0 0 q=%b r=%b",
               bus.done, bus.busy, bus.quotient, bus.remainder,
               exp_v[2*N-1:N], exp_v[N-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    int  c, b;
    int  extra;
    bit  g;
    bus.start    = 1'b1;
    bus.dividend = 4'd15;
    bus.divisor  = 4'd1;
    exp_q.push_back(model(4'd15, 4'd1));
    tick();
    bus.dividend = 4'd3;
    bus.divisor  = 4'd7;
    exp_q.push_back(model(4'd3, 4'd7));
    for (int k = 0; k < 2; k++) begin
      wait_done(20, c, b, g);
      n_checks++;
      if (!g || c != N) begin
        n_fail++;
        $display("FAIL b2b_latency%0d: got done=%b cycles=%0d, want 1 %0d", k, g, c, N);
      end
      if (g) begin
        got_v = {bus.div_by_zero, bus.quotient, bus.remainder};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got dbz=%b q=%b r=%b, want dbz=%b q=%b r=%b", k,
                   got_v[2*N], got_v[2*N-1:N], got_v[N-1:0],
                   exp_v[2*N], exp_v[2*N-1:N], exp_v[N-1:0]);
        end
      end
      if (k == 0) begin
        tick();  // DONE -> IDLE
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
          n_fail++;
          $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        tick();  // first IDLE edge accepts the held start
        n_checks++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_accept: got busy=%b, want 1", bus.busy);
        end
        bus.start = 1'b0;
      end
    end
    exp_q.delete();
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL b2b_pulse_count: got %0d extra done pulses, want 0", extra);
    end
  endtask

  task automatic test_div_zero();
    int  c, b;
    bit  g;
    start_div(4'd9, 4'd0);
    wait_done(20, c, b, g);
    n_checks++;
    if (!g || c != 0 || b != 0) begin
      n_fail++;
      $display("FAIL dbz_latency: got done=%b cycles=%0d busy=%0d, want 1 0 0", g, c, b);
    end
    if (g) begin
      got_v = {bus.div_by_zero, bus.quotient, bus.remainder};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL dbz_result: got dbz=%b q=%b r=%b, want dbz=%b q=%b r=%b",
                 got_v[2*N], got_v[2*N-1:N], got_v[N-1:0],
                 exp_v[2*N], exp_v[2*N-1:N], exp_v[N-1:0]);
      end
    end else begin
      exp_q.delete();
    end
    tick();
    n_checks++;
    if ({bus.done, bus.div_by_zero} !== 2'b01) begin
      n_fail++;
      $display("FAIL dbz_hold: got done=%b dbz=%b, want 0 1", bus.done, bus.div_by_zero);
    end
    start_div(4'd6, 4'd3);
    n_checks++;
    if ({bus.busy, bus.div_by_zero} !== 2'b10) begin
      n_fail++;
      $display("FAIL dbz_clear: got busy=%b dbz=%b, want 1 0", bus.busy, bus.div_by_zero);
    end
    wait_done(20, c, b, g);
    if (g) begin
      got_v = {bus.div_by_zero, bus.quotient, bus.remainder};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL dbz_next_result: got dbz=%b q=%b r=%b, want dbz=%b q=%b r=%b",
                 got_v[2*N], got_v[2*N-1:N], got_v[N-1:0],
                 exp_v[2*N], exp_v[2*N-1:N], exp_v[N-1:0]);
      end
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int  c, b;
    bit  g;
    start_div(4'd14, 4'd3);
    tick();  // second RUN cycle
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
      n_fail++;
      $display("FAIL abort_async: got busy=%b done=%b dbz=%b q=%b r=%b, want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    start_div(4'd6, 4'd2);
    wait_done(20, c, b, g);
    n_checks++;
    if (!g) begin
      n_fail++;
      $display("FAIL abort_next_timeout: got no done within bound, want done");
      exp_q.delete();
    end else begin
      got_v = {bus.div_by_zero, bus.quotient, bus.remainder};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL abort_next_result: got dbz=%b q=%b r=%b, want dbz=%b q=%b r=%b",
                 got_v[2*N], got_v[2*N-1:N], got_v[N-1:0],
                 exp_v[2*N], exp_v[2*N-1:N], exp_v[N-1:0]);
      end
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int           c, b;
    int           bad;
    bit           g;
    logic [W-1:0] prev;
    prev = exp_v;
    start_div(4'd12, 4'd5);
    tick();
    bus.start    = 1'b1;
    bus.dividend = 4'd5;
    bus.divisor  = 4'd5;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if ({bus.div_by_zero, bus.quotient, bus.remainder} !== prev) begin
      n_fail++;
      $display("FAIL ignore_run_hold: got q=%b r=%b, want q=%b r=%b",
               bus.quotient, bus.remainder, prev[2*N-1:N], prev[N-1:0]);
    end
    wait_done(20, c, b, g);
    n_checks++;
    if (!g) begin
      n_fail++;
      $display("FAIL ignore_timeout: got no done within bound, want done");
      exp_q.delete();
    end else begin
      got_v = {bus.div_by_zero, bus.quotient, bus.remainder};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL ignore_result: got dbz=%b q=%b r=%b, want dbz=%b q=%b r=%b",
                 got_v[2*N], got_v[2*N-1:N], got_v[N-1:0],
                 exp_v[2*N], exp_v[2*N-1:N], exp_v[N-1:0]);
      end
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.dividend = 4'(k);
      bus.divisor  = 4'(k + 1);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
          {bus.div_by_zero, bus.quotient, bus.remainder} !== exp_v) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ignore_idle_hold: got %0d unstable idle cycles, want 0", bad);
    end
  endtask

  task automatic test_random();
    int           c, b;
    bit           g;
    logic [N-1:0] a, d;
    for (int k = 0; k < 24; k++) begin
      a = N'($urandom_range(0, (1 << N) - 1));
      d = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
      start_div(a, d);
      wait_done(N + 4, c, b, g);
      n_checks++;
      if (!g) begin
        n_fail++;
        $display("FAIL rand_timeout: %0d/%0d got no done within bound, want done", a, d);
        exp_q.delete();
      end else begin
        got_v = {bus.div_by_zero, bus.quotient, bus.remainder};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL rand_result %b/%b: got dbz=%b q=%b r=%b, want dbz=%b q=%b r=%b",
                   a, d, got_v[2*N], got_v[2*N-1:N], got_v[N-1:0],
                   exp_v[2*N], exp_v[2*N-1:N], exp_v[N-1:0]);
        end
      end
      tick();
    end
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    int           c, b;
    bit           g;
    logic [N-1:0] ta[3];
    logic [N-1:0] tb[3];
    logic [W-1:0] tw[3];
    ta = '{4'b1001, 4'b0111, 4'b1000};
    tb = '{4'b0010, 4'b1110, 4'b1111};
    tw = '{{1'b0, 4'b1101, 4'b1111}, {1'b0, 4'b1101, 4'b0001}, {1'b0, 4'b1000, 4'b0000}};
    for (int k = 0; k < 3; k++) begin
      start_div(ta[k], tb[k]);
      wait_done(20, c, b, g);
      n_checks++;
      if (!g || c != N) begin
        n_fail++;
        $display("FAIL signed_latency%0d: got done=%b cycles=%0d, want 1 %0d", k, g, c, N);
      end
      void'(exp_q.pop_front());
      got_v = {bus.div_by_zero, bus.quotient, bus.remainder};
      n_checks++;
      if (got_v !== tw[k]) begin
        n_fail++;
        $display("FAIL signed_result%0d: got q=%b r=%b, want q=%b r=%b", k,
                 got_v[2*N-1:N], got_v[N-1:0], tw[k][2*N-1:N], tw[k][N-1:0]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_reset_abort();
    test_ignore_start();
    test_random();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider: quotient and remainder of two N-bit operands, one quotient bit per clock.
- Inverse counterpart of the combinational BitwiseMultiplier datapath; replaces the large combinational divid/modu paths in timing-critical builds.
- Start/done handshake; results held stable for the ALU result mux and 7-segment display logic.

Parameters:
- N, 4, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  N  numerator; captured on the accepted start edge.
- divisor  input  N  denominator; captured on the accepted start edge.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle.
- quotient  output  N  result quotient.
- remainder  output  N  result remainder.
- div_by_zero  output  1  high with done when captured divisor was 0; held until next accepted start.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal count=0.
- Reset mid-operation aborts immediately, with no partial results. Outputs return to their reset values.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k latches the operands and clears the working registers.
  - divisor!=0: go to RUN, count=N-1.
  - divisor==0: go to DONE directly with quotient={N{1'b1}}, remainder=dividend, div_by_zero=1.
  - start=0: stay in IDLE.
- RUN, one iteration per edge:
  - Shift {rem,quo} left by 1, bringing in the next dividend bit, MSB first.
  - Trial-subtract the divisor in N+1 bits.
  - If no borrow: rem=trial and quotient bit=1. Otherwise rem is unchanged and quotient bit=0.
  - After N iterations (edge k+N), go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally on the next edge.
- Latency:
  - Normal division: done is high in the cycle after edge k+N, i.e. N+1 edges after the accepted start.
  - Divide-by-zero: done is high in the cycle after edge k.
- busy=1 only in RUN.
- quotient/remainder output registers update only on entry to DONE. They hold their value through IDLE until the next DONE, never showing intermediate values.
- start while busy or in DONE is ignored and not queued. Operand changes after the accepted edge have no effect.
- start held high continuously: a new division is accepted on the first IDLE edge after each DONE. Back-to-back throughput is one result per N+2 cycles.
- Unsigned arithmetic, invariant dividend = quotient*divisor + remainder, remainder < divisor.
- dividend < divisor: quotient=0, remainder=dividend. dividend=0: quotient=0, remainder=0.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined (two's complement operands):
  - Latch-time pre-step: take the magnitudes of both operands and record the signs.
  - Run the same N-cycle unsigned core.
  - On entry to DONE: negate the quotient if the signs differ, and give the remainder the sign of the dividend. Truncation is toward zero.
  - Overflow case (most-negative / -1): quotient = most-negative value (wraps), remainder=0, no extra flag.
  - Divide-by-zero output is unchanged (quotient all ones, remainder=dividend).
  - Latency is identical to unsigned.
- Undefined: purely unsigned, no sign logic synthesized.

Test Plan:
- N=4, reset then start with 13/4 (1101/0100): busy high for 4 cycles, done pulse 5 edges after start, quotient=0011, remainder=0001, div_by_zero=0.
- 15/1 then 3/7 back-to-back, start held high: first result q=1111 r=0000; second accepted on the first IDLE edge after DONE, q=0000 r=0011; done pulses exactly twice.
- 9/0: done in the cycle after the start edge, quotient=1111, remainder=1001, div_by_zero=1, busy never high; the next valid start clears div_by_zero.
- Start 14/3, assert rst on the 2nd RUN cycle: all outputs 0 immediately (asynchronous), state IDLE; a following 6/2 yields q=0011 r=0000.
- start pulsed during RUN with different operands (5/5) while computing 12/5: ignored; result q=0010 r=0010, and outputs are held stable in IDLE until the next start.
- With SEQ_DIVIDER_SIGNED_EN: -7/2 (1001/0010) gives q=1101 (-3), r=1111 (-1); 7/-2 gives q=1101, r=0001; -8/-1 gives q=1000, r=0000.
